// File: rtl/div_unit.sv
// rtl/div_unit.sv - sequential restoring divider, one quotient bit per cycle.
// Define DIV_UNSIGNED_EN to add the is_unsigned port for DIVU.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             uns_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   shifted, diff;

`ifdef DIV_UNSIGNED_EN
  assign uns_op = is_unsigned;
`else
  assign uns_op = 1'b0;
`endif

  assign a_neg = ~uns_op & dividend[WIDTH-1];
  assign b_neg = ~uns_op & divisor[WIDTH-1];
  assign a_abs = a_neg ? -dividend : dividend;
  assign b_abs = b_neg ? -divisor : divisor;

  // One extra bit so the trial subtraction's borrow shows up in diff[WIDTH].
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            dz_d    = 1'b0;
            rem_d   = '0;
            quo_d   = a_abs;
            dvs_d   = b_abs;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = CW'(WIDTH - 1);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        // Truncating division: remainder follows the dividend's sign.
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign div_zero = done & dz_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule
